// File: rtl/bus_downsizer.sv
// bus_downsizer: splits each S_DATA_WIDTH word into RATIO beats of M_DATA_WIDTH, least-significant slice first; `BUS_DOWNSIZER_LAST_EN adds m_last.
// First beat one cycle after accept; m_rdy low stalls the current beat and holds s_rdy low; the last beat overlaps the next accept.
module bus_downsizer #(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_val,
  input  logic [S_DATA_WIDTH-1:0] s_data,
  output logic                    s_rdy,
  output logic                    m_val,
  output logic [M_DATA_WIDTH-1:0] m_data,
  input  logic                    m_rdy
`ifdef BUS_DOWNSIZER_LAST_EN
  ,
  output logic                    m_last
`endif
);

  localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  generate
    if ((S_DATA_WIDTH % M_DATA_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("bus_downsizer: S_DATA_WIDTH must be an integer multiple (>= 2) of M_DATA_WIDTH");
    end
  endgenerate

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [S_DATA_WIDTH-1:0] word, word_nxt;
  logic                    last_beat;
  logic                    s_xfer;
  logic                    m_xfer;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      cnt   <= '0;
      word  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      word  <= word_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word;
    last_beat = (cnt == LAST);
    m_val     = (state == SEND);
    // Accepting on the last beat lets the next word follow with no bubble.
    s_rdy     = !reset && ((state == EMPTY) || (state == SEND && last_beat && m_rdy));
    s_xfer    = s_val && s_rdy;
    m_xfer    = m_val && m_rdy;
    case (state)
      EMPTY: begin
        if (s_xfer) begin
          word_nxt  = s_data;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (m_xfer) begin
          if (!last_beat) begin
            cnt_nxt = cnt + 1'b1;
          end else begin
            cnt_nxt = '0;
            if (s_xfer) word_nxt = s_data;
            else        state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign m_data = m_val ? word[cnt*M_DATA_WIDTH +: M_DATA_WIDTH] : '0;

`ifdef BUS_DOWNSIZER_LAST_EN
  assign m_last = m_val && last_beat;
`endif

endmodule

// File: tb/tb_bus_downsizer.sv
// Directed bench for bus_downsizer (32->8): scoreboard of expected beats checked by an independent monitor,
// plus per-cycle checks of handshake timing, stalls and reset.
module tb_bus_downsizer;

  logic        clock;
  logic        reset;
  logic        s_val;
  logic [31:0] s_data;
  logic        s_rdy;
  logic        m_val;
  logic [7:0]  m_data;
  logic        m_rdy;
`ifdef BUS_DOWNSIZER_LAST_EN
  logic        m_last;
`endif

  bus_downsizer #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .s_val  (s_val),
    .s_data (s_data),
    .s_rdy  (s_rdy),
    .m_val  (m_val),
    .m_data (m_data),
    .m_rdy  (m_rdy)
`ifdef BUS_DOWNSIZER_LAST_EN
    ,
    .m_last (m_last)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q.push_back(b);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_beat(w[8*i +: 8], i == 3);
  endtask

  task automatic set(input logic sv, input logic [31:0] sd, input logic mr);
    s_val  = sv;
    s_data = sd;
    m_rdy  = mr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && m_val && m_rdy) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got beat %0h, want no beat", m_data);
      end else begin
        beat_t e;
        e = q.pop_front();
        tests++;
        if (m_data !== e.d) begin
          fails++;
          $display("FAIL sb_data: got %0h, want %0h", m_data, e.d);
        end
`ifdef BUS_DOWNSIZER_LAST_EN
        tests++;
        if (m_last !== e.l) begin
          fails++;
          $display("FAIL sb_last: got %0b, want %0b (data %0h)", m_last, e.l, e.d);
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    set(1'b0, 32'h0, 1'b0);
    tick();
    @(negedge clock);
    chk("rst_s_rdy", {31'b0, s_rdy}, 32'd0);
    chk("rst_m_val", {31'b0, m_val}, 32'd0);
    chk("rst_m_data", {24'b0, m_data}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("idle_s_rdy", {31'b0, s_rdy}, 32'd1);
    chk("idle_m_val", {31'b0, m_val}, 32'd0);

    // Single word, continuous m_rdy
    tick();
    set(1'b1, 32'h04030201, 1'b1);
    push_word(32'h04030201);
    @(negedge clock);
    chk("t1_acc_s_rdy", {31'b0, s_rdy}, 32'd1);
    tick();
    set(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t1_m_val", {31'b0, m_val}, 32'd1);
      chk("t1_m_data", {24'b0, m_data}, i + 1);
      chk("t1_s_rdy", {31'b0, s_rdy}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clock);
    chk("t1_end_m_val", {31'b0, m_val}, 32'd0);
    chk("t1_end_s_rdy", {31'b0, s_rdy}, 32'd1);

    // Back-to-back words with no bubble
    tick();
    set(1'b1, 32'h44332211, 1'b1);
    push_word(32'h44332211);
    push_word(32'h88776655);
    @(negedge clock);
    chk("t2_acc_s_rdy", {31'b0, s_rdy}, 32'd1);
    tick();
    set(1'b1, 32'h88776655, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("t2_m_val", {31'b0, m_val}, 32'd1);
      chk("t2_m_data", {24'b0, m_data}, 32'h11 * (i + 1));
      chk("t2_s_rdy", {31'b0, s_rdy}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
      tick();
      if (i == 3) set(1'b0, 32'h0, 1'b1);
    end
    @(negedge clock);
    chk("t2_end_m_val", {31'b0, m_val}, 32'd0);

    // Backpressure mid-word and on the last beat; junk s_data offered while stalled
    tick();
    set(1'b1, 32'hDDCCBBAA, 1'b1);
    push_word(32'hDDCCBBAA);
    @(negedge clock);
    tick();
    set(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    chk("t3_first", {24'b0, m_data}, 32'hAA);
    tick();
    set(1'b1, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_stall_m_val", {31'b0, m_val}, 32'd1);
      chk("t3_stall_m_data", {24'b0, m_data}, 32'hBB);
      chk("t3_stall_s_rdy", {31'b0, s_rdy}, 32'd0);
      tick();
    end
    set(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    chk("t3_resume", {24'b0, m_data}, 32'hBB);
    tick();
    @(negedge clock);
    chk("t3_cc", {24'b0, m_data}, 32'hCC);
    tick();
    set(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    chk("t3_last_stall_data", {24'b0, m_data}, 32'hDD);
    chk("t3_last_stall_s_rdy", {31'b0, s_rdy}, 32'd0);
    tick();
    set(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    chk("t3_last_data", {24'b0, m_data}, 32'hDD);
    chk("t3_last_s_rdy", {31'b0, s_rdy}, 32'd1);
    tick();
    @(negedge clock);
    chk("t3_end_m_val", {31'b0, m_val}, 32'd0);

    // Reset mid-word, with simultaneous master and slave transfer attempts
    tick();
    set(1'b1, 32'h04030201, 1'b1);
    push_beat(8'h01, 1'b0);
    @(negedge clock);
    tick();
    set(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    chk("t4_beat1", {24'b0, m_data}, 32'h01);
    tick();
    reset = 1'b1;
    set(1'b1, 32'hBADBADBA, 1'b1);
    @(negedge clock);
    chk("t4_rst_s_rdy", {31'b0, s_rdy}, 32'd0);
    tick();
    reset = 1'b0;
    set(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    chk("t4_post_m_val", {31'b0, m_val}, 32'd0);
    chk("t4_post_m_data", {24'b0, m_data}, 32'h0);
    chk("t4_post_s_rdy", {31'b0, s_rdy}, 32'd1);
    tick();
    set(1'b1, 32'h000000EE, 1'b1);
    push_word(32'h000000EE);
    @(negedge clock);
    tick();
    set(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    chk("t4_first_after_rst", {24'b0, m_data}, 32'hEE);
    chk("t4_first_m_val", {31'b0, m_val}, 32'd1);
    for (int i = 0; i < 4; i++) tick();

    @(negedge clock);
    #1;
    chk("sb_drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
